// File: rtl/sdpram_pkg.sv
// Shared types and the byte-lane merge helper for the sdpram_pipe RAM.
// merge() works on a fixed maximum width; callers widen with size casts and truncate the result.
package sdpram_pkg;

    localparam int MAX_DATA_WIDTH = 512;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Lanes whose strobe is set take new_word, the remaining lanes keep old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_STRB_WIDTH-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdpram_core.sv
// Storage array with a byte-lane write port and a single registered read port.
// The caller guarantees in-range addresses whenever wena is non-zero or rd_zero is low.
module sdpram_core
    import sdpram_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter int        MEM_DEPTH  = 1024,
    parameter int        ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int        STRB_WIDTH = DATA_WIDTH / 8,
    parameter rdw_mode_e RDW_MODE   = READ_FIRST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STRB_WIDTH-1:0] wena,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  renb,
    input  logic                  rd_zero,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] merged_s;
    logic                  collide_s;
    logic [DATA_WIDTH-1:0] doutb_r;

    // New word for the write port and same-address collision detect.
    always_comb begin
        merged_s  = DATA_WIDTH'(merge(MAX_DATA_WIDTH'(mem[addra]),
                                      MAX_DATA_WIDTH'(dina),
                                      MAX_STRB_WIDTH'(wena)));
        collide_s = (wena != {STRB_WIDTH{1'b0}}) && (addra == addrb);
    end

    // Storage update; the array has no reset because the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (wena != {STRB_WIDTH{1'b0}}) begin
            mem[addra] <= merged_s;
        end
    end

    // Read register: WRITE_FIRST forwards the merged word on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            doutb_r <= {DATA_WIDTH{1'b0}};
        end else if (renb) begin
            if (rd_zero) begin
                doutb_r <= {DATA_WIDTH{1'b0}};
            end else if ((RDW_MODE == WRITE_FIRST) && collide_s) begin
                doutb_r <= merged_s;
            end else begin
                doutb_r <= mem[addrb];
            end
        end
    end

    assign doutb = doutb_r;

endmodule

// File: rtl/sdpram_pipe.sv
// Simple dual-port RAM top: clear-after-reset sequencer, address range checks,
// optional second read stage and the read-valid pipeline around sdpram_core.
module sdpram_pipe
    import sdpram_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int ADDR_WIDTH    = $clog2(MEM_DEPTH),
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STRB_WIDTH-1:0] wena,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  renb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutb_valid,
    output logic                  ready
);

    localparam rdw_mode_e           MODE        = (RDW_MODE == 1) ? WRITE_FIRST : READ_FIRST;
    localparam state_e              RESET_STATE = (INIT_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [ADDR_WIDTH:0] DEPTH_L     = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_e                  state_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic                    ready_r;
    logic                    valid1_r;
    logic                    live_s;
    logic                    a_in_range_s;
    logic                    b_in_range_s;
    logic                    rd_fire_s;
    logic [STRB_WIDTH-1:0]   core_wena_s;
    logic [ADDR_WIDTH-1:0]   core_addra_s;
    logic [DATA_WIDTH-1:0]   core_dina_s;
    logic [DATA_WIDTH-1:0]   core_doutb_s;

    // Write-port source select: reset blocks, CLEAR zeroes, RUN passes in-range user writes.
    always_comb begin
        live_s       = ready_r && (state_r == RUN) && !rst;
        a_in_range_s = {1'b0, addra} < DEPTH_L;
        b_in_range_s = {1'b0, addrb} < DEPTH_L;
        rd_fire_s    = live_s && renb;
        if (rst) begin
            core_wena_s  = {STRB_WIDTH{1'b0}};
            core_addra_s = {ADDR_WIDTH{1'b0}};
            core_dina_s  = {DATA_WIDTH{1'b0}};
        end else if (state_r == CLEAR) begin
            core_wena_s  = {STRB_WIDTH{1'b1}};
            core_addra_s = clr_cnt_r;
            core_dina_s  = {DATA_WIDTH{1'b0}};
        end else if (live_s && a_in_range_s) begin
            core_wena_s  = wena;
            core_addra_s = addra;
            core_dina_s  = dina;
        end else begin
            core_wena_s  = {STRB_WIDTH{1'b0}};
            core_addra_s = addra;
            core_dina_s  = dina;
        end
    end

    // Clear sequencer: one word per cycle, then RUN with ready raised on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RESET_STATE;
            clr_cnt_r <= {ADDR_WIDTH{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r   <= RUN;
                        clr_cnt_r <= {ADDR_WIDTH{1'b0}};
                        ready_r   <= 1'b1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
                        ready_r   <= 1'b0;
                    end
                end
                RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= RESET_STATE;
                    clr_cnt_r <= {ADDR_WIDTH{1'b0}};
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    sdpram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .RDW_MODE   (MODE)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .wena    (core_wena_s),
        .addra   (core_addra_s),
        .dina    (core_dina_s),
        .renb    (rd_fire_s),
        .rd_zero (!b_in_range_s),
        .addrb   (addrb),
        .doutb   (core_doutb_s)
    );

    // First valid stage tracks reads captured by the core register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_r <= 1'b0;
        end else begin
            valid1_r <= rd_fire_s;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] doutb2_r;
            logic                  valid2_r;

            // Second stage only loads when the first stage holds fresh data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    doutb2_r <= {DATA_WIDTH{1'b0}};
                    valid2_r <= 1'b0;
                end else begin
                    valid2_r <= valid1_r;
                    if (valid1_r) begin
                        doutb2_r <= core_doutb_s;
                    end
                end
            end

            assign doutb       = doutb2_r;
            assign doutb_valid = valid2_r;
        end else begin : g_lat1
            assign doutb       = core_doutb_s;
            assign doutb_valid = valid1_r;
        end
    endgenerate

    assign ready = ready_r;

endmodule

// File: tb/tb_sdpram_pipe.sv
// Self-checking bench for sdpram_pipe: instance A (16 words, latency 2, READ_FIRST)
// and instance B (1000 words, latency 1, WRITE_FIRST) with per-instance scoreboards.
module tb_sdpram_pipe;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        rst_a = 1'b1;
    logic [3:0]  wena_a = 4'h0;
    logic [3:0]  addra_a = 4'h0;
    logic [31:0] dina_a = 32'h0;
    logic        renb_a = 1'b0;
    logic [3:0]  addrb_a = 4'h0;
    logic [31:0] doutb_a;
    logic        valid_a;
    logic        ready_a;

    logic        rst_b = 1'b1;
    logic [3:0]  wena_b = 4'h0;
    logic [9:0]  addra_b = 10'h0;
    logic [31:0] dina_b = 32'h0;
    logic        renb_b = 1'b0;
    logic [9:0]  addrb_b = 10'h0;
    logic [31:0] doutb_b;
    logic        valid_b;
    logic        ready_b;

    logic [31:0] model_a [16];
    logic [31:0] model_b [1000];
    exp_t        qa [$];
    exp_t        qb [$];

    sdpram_pipe #(
        .DATA_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(2), .RDW_MODE(0), .INIT_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .wena(wena_a), .addra(addra_a), .dina(dina_a),
        .renb(renb_a), .addrb(addrb_a), .doutb(doutb_a), .doutb_valid(valid_a), .ready(ready_a)
    );

    sdpram_pipe #(
        .DATA_WIDTH(32), .MEM_DEPTH(1000), .READ_LATENCY(1), .RDW_MODE(1), .INIT_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .wena(wena_b), .addra(addra_b), .dina(dina_b),
        .renb(renb_b), .addrb(addrb_b), .doutb(doutb_b), .doutb_valid(valid_b), .ready(ready_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge_tb(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        end
        return r;
    endfunction

    task automatic set_idle(input int sel);
        if (sel == 0) begin
            wena_a = 4'h0; renb_a = 1'b0;
        end else begin
            wena_b = 4'h0; renb_b = 1'b0;
        end
    endtask

    // One cycle of stimulus; expected read data is derived from the model at drive time.
    task automatic drive(input int sel, input logic [3:0] we, input int wa, input logic [31:0] wd,
                         input logic re, input int ra);
        exp_t e;
        @(posedge clk); #1;
        if (sel == 0) begin
            wena_a = we; addra_a = 4'(wa); dina_a = wd; renb_a = re; addrb_a = 4'(ra);
            if (re) begin
                e.data = model_a[ra];
                e.cyc  = cyc + 2;
                qa.push_back(e);
            end
            if (we != 4'h0) model_a[wa] = merge_tb(model_a[wa], wd, we);
        end else begin
            wena_b = we; addra_b = 10'(wa); dina_b = wd; renb_b = re; addrb_b = 10'(ra);
            if (re) begin
                if (ra >= 1000) e.data = 32'h0;
                else if (we != 4'h0 && wa == ra) e.data = merge_tb(model_b[ra], wd, we);
                else e.data = model_b[ra];
                e.cyc = cyc + 1;
                qb.push_back(e);
            end
            if (we != 4'h0 && wa < 1000) model_b[wa] = merge_tb(model_b[wa], wd, we);
        end
    endtask

    task automatic idle(input int sel, input int n);
        repeat (n) drive(sel, 4'h0, 0, 32'h0, 1'b0, 0);
    endtask

    task automatic apply_reset(input int sel, input int cycles);
        @(posedge clk); #1;
        set_idle(sel);
        if (sel == 0) begin
            rst_a = 1'b1; qa.delete();
            for (int i = 0; i < 16; i++) model_a[i] = 32'h0;
        end else begin
            rst_b = 1'b1; qb.delete();
            for (int i = 0; i < 1000; i++) model_b[i] = 32'h0;
        end
        repeat (cycles) @(posedge clk);
        #1;
        if (sel == 0) begin
            check_eq("a_rst_ready", 32'(ready_a), 32'd0);
            check_eq("a_rst_dout", doutb_a, 32'h0);
            check_eq("a_rst_valid", 32'(valid_a), 32'd0);
            rst_a = 1'b0;
        end else begin
            check_eq("b_rst_ready", 32'(ready_b), 32'd0);
            check_eq("b_rst_dout", doutb_b, 32'h0);
            check_eq("b_rst_valid", 32'(valid_b), 32'd0);
            rst_b = 1'b0;
        end
    endtask

    // Counts edges after reset release until ready is seen; inputs go idle on that cycle.
    task automatic wait_ready(input int sel, input int exp_len, input string tag);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 3000) begin
            @(posedge clk); #1;
            n++;
            rdy = (sel == 0) ? ready_a : ready_b;
        end
        set_idle(sel);
        check_eq(tag, 32'(n), 32'(exp_len));
    endtask

    // Scoreboard for A: every valid pulse must match the oldest pending read.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (valid_a === 1'b1) begin
            check_eq("a_pending", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check_eq("a_data", doutb_a, e.data);
                check_eq("a_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Scoreboard for B.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (valid_b === 1'b1) begin
            check_eq("b_pending", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check_eq("b_data", doutb_b, e.data);
                check_eq("b_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // A: clear length and zeroed contents
        apply_reset(0, 2);
        wait_ready(0, 16, "a_clear_len");
        for (int i = 0; i < 16; i++) drive(0, 4'h0, 0, 32'h0, 1'b1, i);
        idle(0, 4);

        // A: back-to-back reads at latency 2
        for (int i = 1; i <= 4; i++) drive(0, 4'hF, i, 32'h100 + 32'(i), 1'b0, 0);
        for (int i = 1; i <= 4; i++) drive(0, 4'h0, 0, 32'h0, 1'b1, i);
        idle(0, 4);

        // A: READ_FIRST collision, then a write while the read is still in flight
        drive(0, 4'hF, 5, 32'hDEADBEEF, 1'b1, 5);
        drive(0, 4'hF, 5, 32'h12345678, 1'b0, 0);
        idle(0, 3);
        drive(0, 4'h0, 0, 32'h0, 1'b1, 5);
        idle(0, 4);

        // A: reset one cycle after a read; no valid pulse may follow
        drive(0, 4'h0, 0, 32'h0, 1'b1, 3);
        apply_reset(0, 1);
        wait_ready(0, 16, "a_clear_len_after_read");
        check_eq("a_dout_after_clear", doutb_a, 32'h0);

        // A: reset at cycle 5 of CLEAR while user ports try to write and read
        for (int i = 1; i <= 4; i++) drive(0, 4'hF, i, 32'hA5A5_0000 + 32'(i), 1'b0, 0);
        idle(0, 1);
        apply_reset(0, 1);
        repeat (4) @(posedge clk);
        apply_reset(0, 1);
        wena_a = 4'hF; addra_a = 4'd2; dina_a = 32'hFFFF_FFFF; renb_a = 1'b1; addrb_a = 4'd2;
        wait_ready(0, 16, "a_clear_len_restart");
        for (int i = 0; i < 16; i++) drive(0, 4'h0, 0, 32'h0, 1'b1, i);
        idle(0, 4);

        // B: clear, byte strobes, WRITE_FIRST collision, out-of-range accesses
        apply_reset(1, 2);
        wait_ready(1, 1000, "b_clear_len");
        drive(1, 4'hF, 16, 32'hAABBCCDD, 1'b0, 0);
        drive(1, 4'b0101, 16, 32'h11223344, 1'b0, 0);
        drive(1, 4'h0, 0, 32'h0, 1'b1, 16);
        drive(1, 4'hF, 5, 32'hDEADBEEF, 1'b1, 5);
        drive(1, 4'hF, 7, 32'h11111111, 1'b0, 0);
        drive(1, 4'b0011, 7, 32'h22222222, 1'b1, 7);
        drive(1, 4'hF, 8, 32'hABCD0000, 1'b1, 7);
        drive(1, 4'hF, 1000, 32'h12345678, 1'b0, 0);
        drive(1, 4'hF, 1023, 32'hFFFF0000, 1'b0, 0);
        drive(1, 4'h0, 0, 32'h0, 1'b1, 1000);
        drive(1, 4'h0, 0, 32'h0, 1'b1, 0);
        drive(1, 4'h0, 0, 32'h0, 1'b1, 1023);
        drive(1, 4'h0, 0, 32'h0, 1'b1, 8);
        drive(1, 4'h0, 0, 32'h0, 1'b1, 24);
        idle(1, 4);

        check_eq("a_queue_drained", 32'(qa.size()), 32'd0);
        check_eq("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdpram_pipe.md
Name: sdpram_pipe

Overview:
- Next-generation simple dual-port RAM: write port A, read port B, one clock domain.
- Adds byte-lane write strobes, a parametrised read latency of 1 or 2, a selectable read-during-write mode, an optional clear-on-reset sequencer, and a read-valid output.
- Drop-in storage for buffers and descriptor tables; the existing sdpram bench drives it through the same signal names.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be a multiple of 8.
- MEM_DEPTH, 1024, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, number of byte-lane write strobes.
- READ_LATENCY, 1, cycles from renb to doutb_valid; legal values are 1 and 2 only.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data).
- INIT_ON_RESET, 1, 1 = zero every word after reset, 0 = memory contents undefined after reset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wena  in  STRB_WIDTH  byte write strobes; bit i writes dina[8i+7:8i].
- addra  in  ADDR_WIDTH  write address.
- dina  in  DATA_WIDTH  write data.
- renb  in  1  read enable.
- addrb  in  ADDR_WIDTH  read address.
- doutb  out  DATA_WIDTH  read data, registered.
- doutb_valid  out  1  one-cycle pulse: doutb holds the data for a read.
- ready  out  1  high when the RAM accepts accesses.

Behaviour:
- Reset (rst=1 sampled at a rising edge):
  - doutb=0, doutb_valid=0, ready=0, all read pipeline stages cleared, clear counter=0.
  - Takes precedence over every other input.
- State machine:
  - States are CLEAR and RUN.
  - rst forces CLEAR when INIT_ON_RESET=1, or RUN (entered on the first cycle after reset) when INIT_ON_RESET=0.
  - In CLEAR:
    - One word at the counter address is written to zero each cycle, and the counter increments.
    - After address MEM_DEPTH-1 is written, the next state is RUN.
    - Total CLEAR duration is MEM_DEPTH cycles.
    - wena and renb are ignored; doutb_valid stays 0.
  - RUN: ready=1 and the user ports are live.
  - Asserting rst during CLEAR restarts the counter at 0.
- Write:
  - In RUN, the word at addra is updated on the edge: each lane with wena[i]=1 takes dina lane i; other lanes are unchanged.
  - wena=0 means no write.
- Read:
  - Sampled on the edge when renb=1 in RUN.
  - READ_LATENCY=1: doutb and doutb_valid update on the next edge.
  - READ_LATENCY=2: one extra register stage is added.
  - doutb holds its last value when no read is in flight; doutb_valid is 1 only in the cycle the new data appears.
  - Back-to-back reads are accepted every cycle, giving full throughput.
- Out-of-range addresses (addr >= MEM_DEPTH):
  - The write is dropped with no aliasing.
  - The read returns 0 with doutb_valid=1.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the old word with strobed lanes replaced by dina.
  - Different addresses never interact.
- READ_LATENCY=2: the returned data is the memory value at the read sample edge, with RDW_MODE applied there. A write in the following cycle does not alter the in-flight read.
- Reset mid-read: in-flight reads are discarded and no doutb_valid pulse follows.

Decomposition:
- Package sdpram_pkg holds:
  - the rdw_mode_e enum (READ_FIRST, WRITE_FIRST);
  - the state_e enum (CLEAR, RUN);
  - the byte-merge function merge(old, new, strb).
- One sub-module, sdpram_core: storage array, byte-lane write, and a single registered read with RDW handling.
- The top level adds the clear sequencer, the address range check, and the optional second read stage plus the valid pipeline.

Test Plan:
- Clear sequence: rst high 2 cycles, MEM_DEPTH=16, INIT_ON_RESET=1 -> ready rises exactly 16 cycles after rst falls; reads of addresses 0..15 return 0.
- Byte strobes: write 0xAABBCCDD at 0x10 with wena=4'hF, then write 0x11223344 with wena=4'b0101 -> read 0x10 returns 0xAA22CC44.
- Latency and throughput: READ_LATENCY=2, renb held 4 cycles at addresses 1,2,3,4 preloaded with 0x101..0x104 -> doutb_valid high for 4 consecutive cycles, starting 2 edges after the first renb, with data 0x101..0x104 in order.
- Collision: word at 0x5 = 0x0; in one cycle write 0xDEADBEEF at 0x5 with wena=F and read 0x5 -> RDW_MODE=0 returns 0x0; RDW_MODE=1 returns 0xDEADBEEF.
- Out-of-range: MEM_DEPTH=1000, write 0x12345678 to address 1000, then read 1000 and read 0 -> both return 0; address 0 not aliased.
- Reset mid-operation: assert rst at cycle 5 of CLEAR, and separately one cycle after a renb -> counter restarts, full MEM_DEPTH clear repeats, no doutb_valid pulse, doutb=0.
